// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: op codes, flag bundle and multiplier FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle; used only when ALU_MUL_EN is defined.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy_c,
    output logic                 done_c,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    mul_state_e       state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath: LSB of the multiplier gates each shifted multiplicand into the sum
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = MUL_BUSY;
                    acc_d    = '0;
                    mcand_d  = PW'(a);
                    mplier_d = b;
                    cnt_d    = '0;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign busy_c  = (state_q != IDLE);
    assign done_c  = (state_q == MUL_DONE);
    assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with a registered result/flag stage and backpressure.
// Define ALU_MUL_EN to enable op 111 as an iterative multiply; otherwise op 111 is reserved.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int unsigned SUM_W = WIDTH + 1;

    alu_op_e          op_e;
    logic [WIDTH-1:0] b_eff;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    alu_flags_t       alu_flags;

    logic             idle;
    logic             xfer;
    logic             load_alu;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_res;
    logic             mul_carry;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    alu_flags_t       flags_q;

    assign op_e  = alu_op_e'(op);
    assign b_eff = (op_e == OP_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + SUM_W'(op_e == OP_SUB);

    // Single-cycle op datapath; MUL/reserved falls through to zero
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_e)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD, OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: alu_res = a ^ b;
            OP_SLT: alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SHL: alu_res = a << b[SHAMT_W-1:0];
            default: alu_res = '0;
        endcase
        alu_flags = '{c: alu_carry, z: (alu_res == '0), n: alu_res[WIDTH-1], v: alu_ovf};
    end

    assign xfer     = in_valid && in_ready;
    assign in_ready = idle && (!out_valid_q || out_ready);

`ifdef ALU_MUL_EN
    logic               mul_busy_c;
    logic [2*WIDTH-1:0] mul_product;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (xfer && (op_e == OP_MUL)),
        .a       (a),
        .b       (b),
        .busy_c  (mul_busy_c),
        .done_c  (mul_done_c),
        .product (mul_product)
    );

    assign idle      = !mul_busy_c;
    assign load_alu  = xfer && (op_e != OP_MUL);
    assign mul_res   = mul_product[WIDTH-1:0];
    assign mul_carry = |mul_product[2*WIDTH-1:WIDTH];
`else
    assign idle       = 1'b1;
    assign load_alu   = xfer;
    assign mul_done_c = 1'b0;
    assign mul_res    = '0;
    assign mul_carry  = 1'b0;
`endif

    // Output stage: a new load wins over a pop so simultaneous pop+accept leaves no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (load_alu) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            flags_q     <= alu_flags;
        end else if (mul_done_c) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_res;
            flags_q     <= '{c: mul_carry, z: (mul_res == '0), n: mul_res[WIDTH-1], v: 1'b0};
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = flags_q.c;
    assign zero      = flags_q.z;
    assign negative  = flags_q.n;
    assign overflow  = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8) against an arithmetic reference model.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       negative;
    logic       overflow;

    logic [11:0] obs;
    int n_checks = 0;
    int n_pass   = 0;

`ifdef ALU_MUL_EN
    localparam int MUL_WAIT = 9;
`else
    localparam int MUL_WAIT = 0;
`endif

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    assign obs = {result, carry_out, zero, negative, overflow};

    // Reference: {result, c, z, n, v} from plain integer arithmetic
    function automatic logic [11:0] model(input int ia, input int ib, input int iop);
        int r, sa, sb, s;
        bit c, v;
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        r = 0; c = 0; v = 0;
        case (iop)
            0: r = ia & ib;
            1: r = ia | ib;
            2: begin
                s = ia + ib; r = s % 256; c = (s > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            3: begin
                r = (ia - ib + 256) % 256; c = (ia >= ib);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            4: r = ia ^ ib;
            5: r = (sa < sb) ? 1 : 0;
            6: r = (ia << (ib % 8)) % 256;
            default: begin
`ifdef ALU_MUL_EN
                s = ia * ib; r = s % 256; c = ((s / 256) != 0);
`else
                r = 0;
`endif
            end
        endcase
        return {8'(r), c, (r == 0), (r >= 128), v};
    endfunction

    task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop);
        int k = 0;
        @(negedge clk);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        #1;
        while (!in_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        if (k >= 50) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        #12;
        n_checks++;
        if (obs !== 12'h000) $display("FAIL reset_outputs: got %h, required 000", obs); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [30:0] vec [9];
        vec = '{ {3'd2, 8'h7F, 8'h01, 8'h80, 4'b0011},
                 {3'd2, 8'hFF, 8'h01, 8'h00, 4'b1100},
                 {3'd3, 8'h05, 8'h05, 8'h00, 4'b1100},
                 {3'd3, 8'h03, 8'h05, 8'hFE, 4'b0010},
                 {3'd5, 8'h80, 8'h01, 8'h01, 4'b0000},
                 {3'd6, 8'h81, 8'h09, 8'h02, 4'b0000},
                 {3'd4, 8'hA5, 8'hFF, 8'h5A, 4'b0000},
                 {3'd0, 8'hF0, 8'h3C, 8'h30, 4'b0000},
                 {3'd1, 8'h00, 8'h00, 8'h00, 4'b0100} };
        for (int i = 0; i < 9; i++) begin
            send(vec[i][27:20], vec[i][19:12], vec[i][30:28]);
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL arith_valid[%0d]: got %b, required 1", i, out_valid); else n_pass++;
            n_checks++;
            if (obs !== vec[i][11:0]) $display("FAIL arith_result[%0d]: got %h, required %h", i, obs, vec[i][11:0]); else n_pass++;
            pop();
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL arith_drain[%0d]: got %b, required 0", i, out_valid); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp [4];
        @(negedge clk); out_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || obs !== exp[k-1])
                    $display("FAIL b2b_result[%0d]: got v=%b %h, required v=1 %h", k-1, out_valid, obs, exp[k-1]);
                else n_pass++;
            end
            if (k < 4) begin
                a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 6));
                exp[k] = model(a, b, op);
                in_valid = 1'b1;
                #1;
                n_checks++;
                if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b, required 1", k, in_ready); else n_pass++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b, required 0", out_valid); else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [11:0] e1, e2;
        logic [7:0] a1, b1;
        a1 = 8'($urandom); b1 = 8'($urandom);
        e1 = model(a1, b1, 2);
        send(a1, b1, 3'd2);
        a = 8'($urandom); b = 8'($urandom); op = 3'd4; in_valid = 1'b1;
        e2 = model(a, b, 4);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, in_ready); else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || obs !== e1)
                $display("FAIL bp_hold[%0d]: got v=%b %h, required v=1 %h", i, out_valid, obs, e1);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b, required 1", in_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || obs !== e2)
            $display("FAIL bp_next: got v=%b %h, required v=1 %h", out_valid, obs, e2);
        else n_pass++;
        pop();
    endtask

    task automatic test_mul();
        int count;
        logic [11:0] exp;
        logic [7:0] ma, mb;
        for (int t = 0; t < 3; t++) begin
            ma = (t == 0) ? 8'h10 : 8'($urandom);
            mb = (t == 0) ? 8'h20 : 8'($urandom);
            exp = model(ma, mb, 7);
            send(ma, mb, 3'd7);
            count = 0;
            while (!out_valid && count < 40) begin
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL mul_busy_ready[%0d]: got %b, required 0", count, in_ready); else n_pass++;
                @(negedge clk);
                count++;
            end
            n_checks++;
            if (count !== MUL_WAIT) $display("FAIL mul_latency: got %0d, required %0d", count, MUL_WAIT); else n_pass++;
            n_checks++;
            if (obs !== exp) $display("FAIL mul_result[%0d]: got %h, required %h", t, obs, exp); else n_pass++;
            if (t == 0) begin
`ifdef ALU_MUL_EN
                n_checks++;
                if (obs !== 12'h00C) $display("FAIL mul_directed: got %h, required 00c", obs); else n_pass++;
`else
                n_checks++;
                if (obs !== 12'h004) $display("FAIL mul_reserved: got %h, required 004", obs); else n_pass++;
`endif
            end
            pop();
        end
    endtask

    task automatic test_reset_mid_mul();
        send(8'h33, 8'h47, 3'd7);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 12'h000 || out_valid !== 1'b0)
            $display("FAIL rst_mid_outputs: got v=%b %h, required v=0 000", out_valid, obs);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b, required 1", in_ready); else n_pass++;
        send(8'h02, 8'h03, 3'd2);
        n_checks++;
        if (out_valid !== 1'b1 || obs !== 12'h050)
            $display("FAIL rst_mid_add: got v=%b %h, required v=1 050", out_valid, obs);
        else n_pass++;
        pop();
        repeat (12) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_no_replay: got %b, required 0", out_valid); else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [11:0] q [$];
        logic [11:0] exp;
        int k;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL stream_spurious: got %h, required no result", obs);
                else begin
                    exp = q.pop_front();
                    if (obs !== exp) $display("FAIL stream_result[%0d]: got %h, required %h", cyc, obs, exp);
                    else n_pass++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, op));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (q.size() > 0 && k < 100) begin
            #1;
            if (out_valid) begin
                exp = q.pop_front();
                n_checks++;
                if (obs !== exp) $display("FAIL stream_drain: got %h, required %h", obs, exp); else n_pass++;
            end
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (q.size() != 0) $display("FAIL stream_left: got %0d pending, required 0", q.size()); else n_pass++;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_mul();
        test_reset_mid_mul();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
